// File: rtl/gray_rd_arbiter.sv
// Round-robin arbiter sharing one gray-image read port between two engines.
// Define GRAY_RD_ARB_LOCK_EN to let a port hold the grant for bursts of up to MAX_BURST reads.
module gray_rd_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    input  logic [DATA_W-1:0] gray_data,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              arb_idle
);

    typedef enum logic {WAIT_MEM, RUN} state_t;

    state_t     state, state_nxt;
    logic       prio;
    logic       pick1;
    logic [1:0] vld_pipe;
    logic [1:0] id_pipe;

`ifdef GRAY_RD_ARB_LOCK_EN
    localparam logic [2:0] BURST_MAX = 3'(MAX_BURST);
    logic       owner;
    logic [2:0] burst_cnt;
    logic       hold;
    logic       gnt_lock;

    // The current owner keeps the port while it stays locked, until the burst cap forces one round-robin pick.
    assign hold     = (burst_cnt < BURST_MAX) &&
                      (owner ? (req1 && lock1) : (req0 && lock0));
    assign gnt_lock = gnt1 ? lock1 : lock0;
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
`endif

    always_comb begin
`ifdef GRAY_RD_ARB_LOCK_EN
        if (hold) pick1 = owner;
        else      pick1 = req1 && (!req0 || prio);
`else
        pick1 = req1 && (!req0 || prio);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WAIT_MEM;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            WAIT_MEM: if (gray_ready) state_nxt = RUN;
            RUN: begin
                gnt1 = pick1;
                gnt0 = req0 && !pick1;
            end
            default: state_nxt = WAIT_MEM;
        endcase
    end

    // vld_pipe[0] is the memory strobe cycle, vld_pipe[1] is the data-return cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio      <= 1'b0;
            gray_addr <= '0;
            vld_pipe  <= '0;
            id_pipe   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], gnt0 | gnt1};
            id_pipe  <= {id_pipe[0], gnt1};
            if (gnt0 | gnt1) prio <= gnt0;
            if (gnt1)      gray_addr <= addr1;
            else if (gnt0) gray_addr <= addr0;
        end
    end

`ifdef GRAY_RD_ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= 1'b0;
            burst_cnt <= '0;
        end else if (gnt0 | gnt1) begin
            owner <= gnt1;
            if (!gnt_lock || burst_cnt == BURST_MAX) burst_cnt <= '0;
            else if (gnt1 != owner)                  burst_cnt <= 3'd1;
            else                                     burst_cnt <= burst_cnt + 3'd1;
        end else if (!(owner ? lock1 : lock0)) begin
            burst_cnt <= '0;
        end
    end
`endif

    assign gray_req = vld_pipe[0];
    assign rvalid0  = vld_pipe[1] && !id_pipe[1];
    assign rvalid1  = vld_pipe[1] &&  id_pipe[1];
    assign rdata0   = gray_data;
    assign rdata1   = gray_data;
    assign arb_idle = (state == RUN) && !(|vld_pipe) && !req0 && !req1;

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Directed bench for gray_rd_arbiter: ready gating, routing, alternation, idle and reset abort.
module tb_gray_rd_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        gray_ready;
    logic [7:0]  gray_data = 8'h00;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic        req0, req1, lock0, lock1;
    logic [13:0] addr0, addr1;
    logic        gnt0, gnt1, rvalid0, rvalid1, arb_idle;
    logic [7:0]  rdata0, rdata1;

    int checks = 0;
    int errors = 0;
    int g[10];

    gray_rd_arbiter dut (
        .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_data(gray_data),
        .gray_req(gray_req), .gray_addr(gray_addr),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .arb_idle(arb_idle)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_fn(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hA5;
    endfunction

    // Memory: data for a strobed address appears the following cycle.
    always @(posedge clk) if (gray_req) gray_data <= mem_fn(gray_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef GRAY_RD_ARB_LOCK_EN
        g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
        g = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
        reset = 1'b1; gray_ready = 1'b0;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0;

        @(negedge clk);
        chk("rst_gray_req", 32'(gray_req), 0);
        chk("rst_gray_addr", 32'(gray_addr), 0);
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 0);
        chk("rst_idle", 32'(arb_idle), 0);

        // Memory not ready: request must be held off.
        step(); reset = 1'b0; req0 = 1'b1; addr0 = 14'h0081;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("nordy_gnt0", 32'(gnt0), 0);
            chk("nordy_req", 32'(gray_req), 0);
            step();
        end
        gray_ready = 1'b1;
        @(negedge clk); chk("rdy_cycle_gnt0", 32'(gnt0), 0);
        step();
        @(negedge clk);
        chk("first_gnt0", 32'(gnt0), 1);
        chk("first_gnt1", 32'(gnt1), 0);
        step(); req0 = 1'b0; gray_ready = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(gray_req), 1);
        chk("first_addr", 32'(gray_addr), 32'h0081);
        chk("first_gnt0_low", 32'(gnt0), 0);

        // Single req1 pulse overlapping the port-0 data return; ready now low (sticky).
        step(); req1 = 1'b1; addr1 = 14'h2AAA;
        @(negedge clk);
        chk("first_rvalid0", 32'(rvalid0), 1);
        chk("first_rdata0", 32'(rdata0), 32'h24);
        chk("first_rvalid1", 32'(rvalid1), 0);
        chk("p1_gnt1", 32'(gnt1), 1);
        chk("p1_gnt0", 32'(gnt0), 0);
        step(); req1 = 1'b0;
        @(negedge clk);
        chk("p1_req", 32'(gray_req), 1);
        chk("p1_addr", 32'(gray_addr), 32'h2AAA);
        chk("p1_rvalid_early", 32'({rvalid1, rvalid0}), 0);
        step();
        @(negedge clk);
        chk("p1_rvalid1", 32'(rvalid1), 1);
        chk("p1_rdata1", 32'(rdata1), 32'h25);
        chk("p1_rvalid0", 32'(rvalid0), 0);
        chk("p1_busy", 32'(arb_idle), 0);
        step();
        @(negedge clk);
        chk("p1_idle", 32'(arb_idle), 1);
        chk("p1_req_low", 32'(gray_req), 0);
        chk("p1_addr_hold", 32'(gray_addr), 32'h2AAA);
        chk("p1_rvalid_done", 32'(rvalid1), 0);

        // Both ports requesting continuously, port 0 locked.
        step(); req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1;
        addr0 = 14'h0100; addr1 = 14'h3F00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("alt_gnt0_%0d", i), 32'(gnt0), 32'(g[i] == 0));
            chk($sformatf("alt_gnt1_%0d", i), 32'(gnt1), 32'(g[i] == 1));
            if (i >= 1) begin
                chk($sformatf("alt_req_%0d", i), 32'(gray_req), 1);
                chk($sformatf("alt_addr_%0d", i), 32'(gray_addr),
                    (g[i-1] == 1) ? 32'h3F00 : 32'h0100);
            end
            if (i >= 2) begin
                chk($sformatf("alt_rv0_%0d", i), 32'(rvalid0), 32'(g[i-2] == 0));
                chk($sformatf("alt_rv1_%0d", i), 32'(rvalid1), 32'(g[i-2] == 1));
                chk($sformatf("alt_rdata_%0d", i), 32'((g[i-2] == 1) ? rdata1 : rdata0),
                    (g[i-2] == 1) ? 32'h9A : 32'hA4);
            end
            step();
        end
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        step(); step();
        @(negedge clk); chk("alt_idle", 32'(arb_idle), 1);

        // Reset the cycle after a grant: read dropped, back to WAIT_MEM.
        step(); req0 = 1'b1; addr0 = 14'h0081;
        @(negedge clk); chk("rst_gnt", 32'(gnt0), 1);
        step(); req0 = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", 32'(gray_req), 0);
        chk("mid_rst_addr", 32'(gray_addr), 0);
        chk("mid_rst_idle", 32'(arb_idle), 0);
        chk("mid_rst_gnt0", 32'(gnt0), 0);
        step();
        @(negedge clk); chk("mid_rst_rvalid", 32'({rvalid1, rvalid0}), 0);
        step(); reset = 1'b0; req0 = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt0", 32'(gnt0), 0);
        chk("post_rst_rvalid", 32'({rvalid1, rvalid0}), 0);
        step(); gray_ready = 1'b1;
        @(negedge clk); chk("post_rst_rdy_gnt0", 32'(gnt0), 0);
        step();
        @(negedge clk); chk("post_rst_run_gnt0", 32'(gnt0), 1);
        step(); req0 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_rd_arbiter.md
# gray_rd_arbiter

Shares the single gray-image read port (gray_addr/gray_req/gray_ready/gray_data) between two requesters: port 0, the LBP engine, and port 1, an auxiliary engine such as a histogram or preview block. It sits between those engines and the external image memory.
- Arbitration: round-robin, one accepted read per cycle, registered address/request outputs.
- Each returned byte is routed back to the port that issued it.
- All grants are held off until the memory has signalled ready.

## Interface
Parameters:
- ADDR_W, 14, address width (128x128 image)
- DATA_W, 8, pixel width
- MAX_BURST, 4, maximum consecutive grants to one locked port (lock feature only)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- gray_ready  in  1  memory ready; sampled, sticky
- gray_data  in  DATA_W  memory read data, valid the cycle after gray_req
- gray_req  out  1  registered memory read strobe
- gray_addr  out  ADDR_W  registered memory read address
- req0, req1  in  1  port read request
- addr0, addr1  in  ADDR_W  port read address, valid with reqN
- lock0, lock1  in  1  hold grant across consecutive reads (used only with GRAY_RD_ARB_LOCK_EN)
- gnt0, gnt1  out  1  combinational accept; the read is accepted at the clock edge ending the cycle
- rvalid0, rvalid1  out  1  registered-path data-valid strobe for the port
- rdata0, rdata1  out  DATA_W  equal to gray_data at all times; qualify with rvalidN
- arb_idle  out  1  high in RUN with no read in flight and no request pending

## Operation
- FSM states:
  - WAIT_MEM: reset state; no grants. Transition to RUN on the first cycle gray_ready=1. Ready is sticky: later gray_ready=0 is ignored.
  - RUN: arbitrate every cycle.
- Grant rule in RUN:
  - Only one request: grant it.
  - Both requests: grant the port selected by the priority pointer `prio` (0 or 1, reset 0).
  - After any grant, `prio` = the other port.
- On grant N at cycle t:
  - t+1: gray_req=1, gray_addr=addrN.
  - t+2: rvalidN=1, with rdataN=gray_data.
  - A 2-entry ID/valid shift pipeline tracks the owner of each in-flight read.
- No requests at t: gray_req=0 at t+1, and gray_addr holds its last value.
- A requester keeps reqN/addrN stable until gntN is seen. Address changes while gnt is low are allowed and take effect in the same cycle.
- Reset mid-operation: the pipeline clears, in-flight reads are dropped with no rvalid, and the FSM returns to WAIT_MEM.
- gnt0 and gnt1 are never high together. rvalid0 and rvalid1 are never high together.

## Timing
- Reset values:
  - gray_req=0, gray_addr=0.
  - gnt0=gnt1=0, rvalid0=rvalid1=0.
  - arb_idle=0 (WAIT_MEM).
  - prio=0, burst count=0.
- Accept-to-data latency: 2 cycles, fixed.
- Throughput: 1 read/cycle sustained. Two continuously requesting ports alternate 0,1,0,1 starting from prio.
- The first grant occurs no earlier than the cycle after gray_ready is first sampled high.
- gray_addr width: zero-extended/truncated to exactly ADDR_W. No address arithmetic in this block.

## Configuration
- GRAY_RD_ARB_LOCK_EN defined:
  - While the current owner keeps reqN=1 and lockN=1, it retains the grant even if the other port requests.
  - A 3-bit burst counter, reset 0, counts consecutive locked grants.
  - At MAX_BURST consecutive grants, the lock is forcibly broken for one arbitration: the other port wins if it is requesting, and the counter clears.
  - The counter also clears on any ownership change or lock deassertion.
- GRAY_RD_ARB_LOCK_EN undefined:
  - lock0 and lock1 are ignored.
  - No counter is built.
  - Pure round-robin.

## Test plan
- Reset, gray_ready=0, req0=1 addr0=0x0081 for 10 cycles -> gnt0=0 and gray_req=0 throughout. Raise gray_ready -> gnt0=1 the next cycle, gray_addr=0x0081 one cycle later, rvalid0=1 two cycles after the grant.
- Both ports request continuously, addr0=0x0100, addr1=0x3F00 -> gray_addr alternates 0x0100, 0x3F00, ... starting with port 0. rvalid0/rvalid1 alternate. The memory model's data returns to the correct port.
- req1 only, single pulse at addr 0x2AAA -> one gray_req, rvalid1 exactly 2 cycles after gnt1, and arb_idle=1 afterwards.
- Reset asserted the cycle after a grant -> no rvalid for that read, outputs at reset values, FSM back in WAIT_MEM.
- GRAY_RD_ARB_LOCK_EN, MAX_BURST=4, lock0=req0=1, req1=1 -> grant sequence 0,0,0,0,1,0,0,0,0,1.
- Without GRAY_RD_ARB_LOCK_EN, same stimulus -> 0,1,0,1.
